// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
//   SEG_BLANK    : all segments off (active-low pattern)
//   AN_OFF       : all anodes off, wide enough for the largest display (8 digits)
//   IDX_W        : width of the digit index (covers up to 8 digits)
//   presc_width(): prescaler width for a given refresh divider (clog2)
package seg_scan_driver_pkg;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [7:0]  AN_OFF    = 8'hFF;
    localparam int unsigned IDX_W     = 32'd3;

    // Prescaler counts 0..div-1, so clog2(div) bits are enough.
    function automatic int unsigned presc_width(input int unsigned div);
        presc_width = (div > 32'd1) ? $clog2(div) : 32'd1;
    endfunction

endpackage

// File: rtl/bin_to_seg.sv
// Hex digit to seven-segment decoder.
//   digit : 4-bit hex value
//   seg   : active-low segments, bit order {g,f,e,d,c,b,a}
module bin_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Combinational hex-to-segment lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver with leading-zero blanking.
//   clk, rst : clock and synchronous active-high reset
//   value    : hex number, digit k = value[4k+3:4k]
//   dp_in    : decimal point per digit, 1 = lit
//   load     : capture value/dp_in into the shadow register
//   blank_lz : suppress digits above the most significant nonzero digit
//   enable   : 0 = display dark, scan frozen
//   seg, dp  : active-low segments and decimal point (registered)
//   an       : active-low anodes, one-hot-low when a digit is lit (registered)
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 32'd4,
    parameter int unsigned REFRESH_DIV = 32'd100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic                      enable,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int unsigned          PW         = presc_width(REFRESH_DIV);
    localparam logic [PW-1:0]        PRESC_LAST = PW'(REFRESH_DIV - 32'd1);
    localparam logic [PW-1:0]        PRESC_ONE  = PW'(32'd1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 32'd1);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(32'd1);
    localparam logic [NUM_DIGITS-1:0] AN_DARK   = AN_OFF[NUM_DIGITS-1:0];

    logic [4*NUM_DIGITS-1:0] shadow_val_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [PW-1:0]           presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    resume_r;   // next enabled cycle is a fresh guard
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;

    logic [3:0]              digit_s;
    logic                    digit_dp_s;
    logic                    upper_nz_s;
    logic                    blanked_s;
    logic [NUM_DIGITS-1:0]   an_lit_s;
    logic [6:0]              code_s;
    logic [PW-1:0]           presc_nxt_s;
    logic [IDX_W-1:0]        idx_nxt_s;
    logic                    resume_nxt_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;
    logic [NUM_DIGITS-1:0]   an_nxt_s;

    // Select the current shadow digit and decide whether it is a leading zero.
    always_comb begin
        digit_s    = 4'h0;
        digit_dp_s = 1'b0;
        upper_nz_s = 1'b0;
        an_lit_s   = AN_DARK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_s     = digit_s | (shadow_val_r[4*k +: 4] & {4{idx_r == IDX_W'(k)}});
            digit_dp_s  = digit_dp_s | (shadow_dp_r[k] & (idx_r == IDX_W'(k)));
            an_lit_s[k] = (idx_r != IDX_W'(k));
            // Any nonzero digit at or above the index keeps this digit visible.
            upper_nz_s  = upper_nz_s |
                          ((shadow_val_r[4*k +: 4] != 4'h0) && (IDX_W'(k) >= idx_r));
        end
        blanked_s = blank_lz & ~upper_nz_s & (idx_r != {IDX_W{1'b0}});
    end

    bin_to_seg u_bin_to_seg (
        .digit (digit_s),
        .seg   (code_s)
    );

    // Scan sequencing and next output values.
    always_comb begin
        presc_nxt_s  = presc_r;
        idx_nxt_s    = idx_r;
        resume_nxt_s = resume_r;
        an_nxt_s     = AN_DARK;
        seg_nxt_s    = SEG_BLANK;
        dp_nxt_s     = 1'b1;
        if (!enable) begin
            resume_nxt_s = 1'b1;
        end else if (resume_r) begin
            // Re-enable guard cycle: counters stay put so the resumed digit
            // keeps its remaining lit time.
            resume_nxt_s = 1'b0;
        end else begin
            if (presc_r == PRESC_LAST) begin
                presc_nxt_s = {PW{1'b0}};
                idx_nxt_s   = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_ONE;
            end else begin
                presc_nxt_s = presc_r + PRESC_ONE;
            end
            // Prescaler 0 is the ghost-guard cycle of the slot.
            if ((presc_r != {PW{1'b0}}) && !blanked_s) begin
                an_nxt_s  = an_lit_s;
                seg_nxt_s = code_s;
                dp_nxt_s  = ~digit_dp_s;
            end else begin
                an_nxt_s  = AN_DARK;
                seg_nxt_s = SEG_BLANK;
                dp_nxt_s  = 1'b1;
            end
        end
    end

    // Shadow register capture; load is honoured whether or not scanning.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
        end else if (load) begin
            shadow_val_r <= value;
            shadow_dp_r  <= dp_in;
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r  <= {PW{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            resume_r <= 1'b0;
            an_r     <= AN_DARK;
            seg_r    <= SEG_BLANK;
            dp_r     <= 1'b1;
        end else begin
            presc_r  <= presc_nxt_s;
            idx_r    <= idx_nxt_s;
            resume_r <= resume_nxt_s;
            an_r     <= an_nxt_s;
            seg_r    <= seg_nxt_s;
            dp_r     <= dp_nxt_s;
        end
    end

    assign seg = seg_r;
    assign dp  = dp_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 4 cycles per slot).
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .enable   (enable),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: shadow contents, digit shown, cycles elapsed in slot,
    // and whether a re-enable guard cycle is owed.
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;
    int          m_digit = 0;
    int          m_tick = 0;
    bit          m_resume = 1'b0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dpi;
        logic        blz;
        int          d;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic chk_seg);
        total++;
        if (an !== e_an || (chk_seg && (seg !== e_seg || dp !== e_dp))) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     name, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    // What a lit digit d should show: blanked if above the most significant nonzero digit.
    task automatic model_lit(input int d, output logic [3:0] e_an, output logic [6:0] e_seg,
                             output logic e_dp);
        int msd;
        logic [3:0] nib;
        msd = 0;
        for (int k = 0; k < ND; k++) begin
            nib = 4'(m_val >> (4*k));
            if (nib != 4'h0) msd = k;
        end
        if (blank_lz && d > msd) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            nib   = 4'(m_val >> (4*d));
            e_an  = 4'hF ^ (4'h1 << d);
            e_seg = hex_code[nib];
            e_dp  = ~m_dp[d];
        end
    endtask

    // One clock: predict from current inputs, advance the model, compare after the edge.
    task automatic tick(input string name);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       chk_seg;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; chk_seg = 1'b0;
        if (rst) chk_seg = 1'b1;
        else if (enable && !m_resume && m_tick != 0) begin
            model_lit(m_digit, e_an, e_seg, e_dp);
            chk_seg = 1'b1;
        end
        if (rst) begin
            m_val = 16'h0000; m_dp = 4'b0000; m_digit = 0; m_tick = 0; m_resume = 1'b0;
        end else begin
            if (load) begin m_val = value; m_dp = dp_in; end
            if (!enable) m_resume = 1'b1;
            else if (m_resume) m_resume = 1'b0;
            else begin
                m_tick++;
                if (m_tick == RD) begin m_tick = 0; m_digit = (m_digit + 1) % ND; end
            end
        end
        @(posedge clk); #1;
        check(name, e_an, e_seg, e_dp, chk_seg);
    endtask

    // Reset pulse followed by a load of v/dpi on the first post-reset edge.
    task automatic reset_and_load(input logic [15:0] v, input logic [3:0] dpi, input logic blz);
        enable = 1'b1; rst = 1'b1; load = 1'b0;
        tick("rst");
        rst = 1'b0; load = 1'b1; value = v; dp_in = dpi; blank_lz = blz;
        tick("load");
        load = 1'b0;
    endtask

    initial begin
        tbl.push_back('{16'h10A1, 4'b0010, 1'b0, 0, 4'b1110, 7'h79, 1'b1});
        tbl.push_back('{16'h10A1, 4'b0010, 1'b0, 1, 4'b1101, 7'h08, 1'b0});
        tbl.push_back('{16'h10A1, 4'b0010, 1'b0, 2, 4'b1011, 7'h40, 1'b1});
        tbl.push_back('{16'h10A1, 4'b0010, 1'b0, 3, 4'b0111, 7'h79, 1'b1});
        tbl.push_back('{16'h0001, 4'b0000, 1'b1, 0, 4'b1110, 7'h79, 1'b1});
        tbl.push_back('{16'h0001, 4'b0000, 1'b1, 1, 4'b1111, 7'h7F, 1'b1});
        tbl.push_back('{16'h0001, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1});
        tbl.push_back('{16'h0000, 4'b1111, 1'b1, 0, 4'b1110, 7'h40, 1'b0});
        tbl.push_back('{16'h0000, 4'b1111, 1'b1, 2, 4'b1111, 7'h7F, 1'b1});
        tbl.push_back('{16'h0000, 4'b1111, 1'b0, 3, 4'b0111, 7'h40, 1'b0});
        tbl.push_back('{16'h0230, 4'b0100, 1'b1, 1, 4'b1101, 7'h30, 1'b1});
        tbl.push_back('{16'h0230, 4'b0100, 1'b1, 2, 4'b1011, 7'h24, 1'b0});
        tbl.push_back('{16'h0230, 4'b0100, 1'b1, 3, 4'b1111, 7'h7F, 1'b1});
        tbl.push_back('{16'h0F00, 4'b1000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1});
        tbl.push_back('{16'h0F00, 4'b1000, 1'b1, 0, 4'b1110, 7'h40, 1'b1});

        // Reset state
        tick("rst0");
        check("reset_state", 4'hF, 7'h7F, 1'b1, 1'b1);

        // Table: first lit cycle of digit d is 4d+2 edges after the reset edge.
        foreach (tbl[i]) begin
            reset_and_load(tbl[i].v, tbl[i].dpi, tbl[i].blz);
            repeat (4*tbl[i].d + 1) tick("scan");
            check($sformatf("tbl_row%0d", i), tbl[i].e_an, tbl[i].e_seg, tbl[i].e_dp, 1'b1);
        end

        // Disable during the digit-2 slot, then resume.
        reset_and_load(16'h10A1, 4'b0010, 1'b0);
        repeat (8) tick("to_d2");
        check("d2_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        enable = 1'b0;
        tick("dis");
        check("dis_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) tick("dis_hold");
        enable = 1'b1;
        tick("reen");
        check("reen_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) begin
            tick("reen_lit");
            check("reen_d2", 4'b1011, 7'h40, 1'b1, 1'b1);
        end
        tick("reen_next");
        check("reen_d3_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick("reen_d3");
        check("reen_d3", 4'b0111, 7'h79, 1'b1, 1'b1);

        // Load coinciding with the digit-0 terminal count.
        reset_and_load(16'h10A1, 4'b0010, 1'b0);
        repeat (2) tick("d0");
        value = 16'hFFFF; load = 1'b1;
        tick("tc_load");
        load = 1'b0;
        check("tc_old_d0", 4'b1110, 7'h79, 1'b1, 1'b1);
        tick("tc_guard");
        check("tc_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick("tc_new");
        check("tc_new_F", 4'b1101, 7'h0E, 1'b0, 1'b1);

        // Reset in the middle of the digit-3 slot.
        reset_and_load(16'h10A1, 4'b0010, 1'b0);
        repeat (12) tick("to_d3");
        check("d3_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        tick("mid_rst");
        check("mid_rst", 4'hF, 7'h7F, 1'b1, 1'b1);
        rst = 1'b0;
        tick("post_rst");
        check("post_rst_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) begin
            tick("post_rst_d0");
            check("post_rst_d0", 4'b1110, 7'h40, 1'b1, 1'b1);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 7) == 0);
            value = r[15:0] >> (4 * $urandom_range(0, 4));
            dp_in = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of hex digits and anodes, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, minimum 4.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS bits: hex number, digit k = value[4k+3:4k].
REQ-007 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point per digit, 1 = lit.
REQ-008 SHALL have port load, input, 1 bit: capture value and dp_in into shadow register.
REQ-009 SHALL have port blank_lz, input, 1 bit: 1 = suppress leading zero digits.
REQ-010 SHALL have port enable, input, 1 bit: 0 = display dark and scan frozen.
REQ-011 SHALL have port seg, output, 7 bits: active-low segments, same bit order as bin_to_seg.
REQ-012 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-013 SHALL have port an, output, NUM_DIGITS bits: active-low anodes, one-hot-low when lit.

Function
REQ-014 SHALL capture value and dp_in into the shadow register on any edge with load=1; the display SHALL use only the shadow register.
REQ-015 SHALL run a prescaler 0..REFRESH_DIV-1 while enable=1; at terminal count the digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-016 SHALL register seg, dp and an, computing them from the index and shadow register as held after the previous edge (1-cycle pipeline).
REQ-017 SHALL drive an all-high (ghost guard) during the first cycle of every digit slot, then an[index]=0 for the remaining REFRESH_DIV-1 cycles.
REQ-018 SHALL, when blank_lz=1, treat every digit above the most significant nonzero shadow digit as blanked: an bit stays high, seg=7'h7F, dp=1; digit 0 SHALL never be blanked.
REQ-019 SHALL, when blank_lz=0, light every digit, including zeros.
REQ-020 SHALL, with enable=0, drive an all-high from the next edge and hold prescaler and index; on re-enable, scanning SHALL resume the same digit with a fresh ghost-guard cycle.
REQ-021 SHALL, when load coincides with a terminal count, apply both; the new digit SHALL show the new shadow value one cycle after the ghost guard.
REQ-022 SHALL still accept load while enable=0.

Reset
REQ-023 SHALL on rst=1 clear shadow value and dp to 0, prescaler to 0 and index to 0, and set an=all 1, seg=7'h7F, dp=1.
REQ-024 SHALL let rst override load and enable; rst mid-scan SHALL take effect on that edge, and the first digit-0 slot SHALL start, with its ghost guard, on the edge after rst deasserts.

Structure
REQ-025 SHALL place constants SEG_BLANK=7'h7F, the anode-off pattern and prescaler width (clog2 of REFRESH_DIV) in the shared display package.
REQ-026 SHALL decode digits through one existing bin_to_seg instance fed by a shadow-digit mux; no other sub-module.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 SHALL cover: rst pulse -> an=4'b1111, seg=7'h7F, dp=1 on the following cycle.
REQ-028 SHALL cover: load 16'h10A1, dp_in=4'b0010, blank_lz=0 -> per 4-cycle slot: 1 guard cycle (an=1111), then an=1110, 1101, 1011, 0111 in turn with bin_to_seg codes 1, A, 0, 1; dp=0 only while an=1101.
REQ-029 SHALL cover: blank_lz=1 with 16'h0001 -> an[3:1] never low, digit 0 shows "1"; with 16'h0000 -> only an[0] ever low, showing "0".
REQ-030 SHALL cover: enable=0 in cycle 2 of the digit-2 slot -> an=1111 next edge; on enable=1 -> 1 guard cycle, then an=1011 for 3 cycles.
REQ-031 SHALL cover: load 16'hFFFF on the terminal count of digit 0 -> guard cycle, then an=1101 with the "F" code.
REQ-032 SHALL cover: rst asserted mid-slot on digit 3 -> reset outputs; after release, digit 0 is lit first, shadow=0 shows "0".
